moore_step_arbiter: RTL and testbench

- Shares one 4-state Moore step counter (S0..S3, advances one state per input pulse, wraps S3->S0, y_out=1 in S3) among N_REQ requesters.
- Each requester asks for the counter to be advanced by a given number of steps.
- A round-robin arbiter grants one requester at a time, and a sequencer FSM issues exactly that many single-cycle step pulses, then signals completion.
- Sits between client FSMs and the shared counter resource.

---
 rtl/moore_step_pkg.sv | 15 +
 rtl/moore_mod4_core.sv | 28 ++
 rtl/moore_step_arbiter.sv | 116 +++++++++++
 tb/tb_moore_step_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/moore_step_pkg.sv
// Shared types for the step arbiter: controller states and counter state encodings.
package moore_step_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

endpackage

// File: rtl/moore_mod4_core.sv
// Four-state Moore step counter: advances one state per x_in pulse, wraps S3->S0.
module moore_mod4_core
  import moore_step_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       x_in,
  output logic [1:0] state,
  output logic       y_out
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S0;
    end else if (x_in) begin
      case (state)
        S0:      state <= S1;
        S1:      state <= S2;
        S2:      state <= S3;
        default: state <= S0;
      endcase
    end
  end

  assign y_out = (state == S3);

endmodule

// File: rtl/moore_step_arbiter.sv
// Round-robin arbiter that lets one requester at a time advance the shared
// mod-4 counter by a requested number of single-cycle step pulses.
module moore_step_arbiter
  import moore_step_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int STEP_W = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*STEP_W-1:0]   steps,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                state_out,
  output logic                      y_out
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set request bit at or after p, wrapping modulo N_REQ. Scanning
  // downward lets the closest candidate to p overwrite the farther ones.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] r, input logic [IDX_W-1:0] p);
    pick_t res;
    int    idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(p) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (r[idx]) begin
        res.valid = 1'b1;
        res.idx   = IDX_W'(idx);
      end
    end
    return res;
  endfunction

  ctrl_state_e       ctrl_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  w_q;
  logic [STEP_W-1:0] remaining_q;
  logic              step_q;

  pick_t             pick;
  logic [STEP_W-1:0] step_sel;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick     = rr_pick(req, ptr_q);
    step_sel = '0;
    if (pick.valid) step_sel = steps[pick.idx*STEP_W +: STEP_W];
  end

  // Outputs are registered alongside the state so they never see req combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q      <= IDLE;
      ptr_q       <= '0;
      w_q         <= '0;
      remaining_q <= '0;
      step_q      <= 1'b0;
      gnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (ctrl_q)
        IDLE: begin
          if (pick.valid) begin
            w_q         <= pick.idx;
            remaining_q <= step_sel;
            gnt         <= N_REQ'(1) << pick.idx;
            busy        <= 1'b1;
            if (step_sel != '0) begin
              ctrl_q <= STEP;
              step_q <= 1'b1;
            end else begin
              ctrl_q <= DONE;
              done   <= 1'b1;
            end
          end
        end
        STEP: begin
          remaining_q <= remaining_q - STEP_W'(1);
          if (remaining_q == STEP_W'(1)) begin
            ctrl_q <= DONE;
            step_q <= 1'b0;
            done   <= 1'b1;
          end
        end
        DONE: begin
          ctrl_q <= IDLE;
          gnt    <= '0;
          busy   <= 1'b0;
          done   <= 1'b0;
          ptr_q  <= (w_q == IDX_W'(N_REQ - 1)) ? '0 : w_q + IDX_W'(1);
        end
        default: ctrl_q <= IDLE;
      endcase
    end
  end

  moore_mod4_core u_core (
    .clock (clock),
    .reset (reset),
    .x_in  (step_q),
    .state (state_out),
    .y_out (y_out)
  );

endmodule

// File: tb/tb_moore_step_arbiter.sv
// Directed and randomized checks of moore_step_arbiter against an operation-level model.
module tb_moore_step_arbiter;

  localparam int N_REQ  = 4;
  localparam int STEP_W = 4;
  localparam int SV_W   = N_REQ * STEP_W;

  logic              clock = 1'b0;
  logic              reset;
  logic [N_REQ-1:0]  req;
  logic [SV_W-1:0]   steps;
  logic [N_REQ-1:0]  gnt;
  logic              busy;
  logic              done;
  logic [1:0]        state_out;
  logic              y_out;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt;   // model counter position 0..3
  int m_ptr;   // model round-robin pointer

  always #5 clock = ~clock;

  moore_step_arbiter #(.N_REQ(N_REQ), .STEP_W(STEP_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .steps     (steps),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .state_out (state_out),
    .y_out     (y_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [N_REQ-1:0] e_gnt, input logic e_busy,
                            input logic e_done, input int e_state);
    check({tag, ".gnt"},   32'(gnt),       32'(e_gnt));
    check({tag, ".busy"},  32'(busy),      32'(e_busy));
    check({tag, ".done"},  32'(done),      32'(e_done));
    check({tag, ".state"}, 32'(state_out), 32'(e_state % 4));
    check({tag, ".y"},     32'(y_out),     32'((e_state % 4) == 3));
  endtask

  function automatic int pick_winner(input logic [N_REQ-1:0] r, input int p);
    for (int off = 0; off < N_REQ; off++)
      if (r[(p + off) % N_REQ]) return (p + off) % N_REQ;
    return -1;
  endfunction

  function automatic logic [SV_W-1:0] pack_steps(input int s0, input int s1, input int s2, input int s3);
    logic [SV_W-1:0] v;
    v = '0;
    v[0*STEP_W +: STEP_W] = STEP_W'(s0);
    v[1*STEP_W +: STEP_W] = STEP_W'(s1);
    v[2*STEP_W +: STEP_W] = STEP_W'(s2);
    v[3*STEP_W +: STEP_W] = STEP_W'(s3);
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    steps = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    m_cnt = 0;
    m_ptr = 0;
  endtask

  // Entered just after a rising edge with the DUT in IDLE; leaves it the same way.
  // mode: 0 hold inputs, 1 drop req and set all steps to 1, 2 randomize inputs after grant.
  task automatic run_op(input string tag, input logic [N_REQ-1:0] r, input logic [SV_W-1:0] s,
                        input int mode);
    int w, k, n;
    logic [STEP_W-1:0] field;
    req   = r;
    steps = s;
    w = pick_winner(r, m_ptr);
    if (w < 0) begin
      @(negedge clock);
      check_outs({tag, ".idle"}, '0, 1'b0, 1'b0, m_cnt);
      @(posedge clock);
      #1;
      return;
    end
    field = s[w*STEP_W +: STEP_W];
    k = int'(field);
    n = (k == 0) ? 1 : k + 1;
    @(posedge clock);
    #1;
    if (mode == 1) begin
      req   = '0;
      steps = pack_steps(1, 1, 1, 1);
    end else if (mode == 2) begin
      req   = N_REQ'($urandom);
      steps = SV_W'($urandom);
    end
    for (int j = 1; j <= n; j++) begin
      @(negedge clock);
      check_outs($sformatf("%s.c%0d", tag, j), N_REQ'(1) << w, 1'b1, (j == n), m_cnt + j - 1);
    end
    @(posedge clock);
    #1;
    m_cnt = (m_cnt + k) % 4;
    m_ptr = (w + 1) % N_REQ;
  endtask

  initial begin
    logic [N_REQ-1:0] r;
    logic [SV_W-1:0]  s;

    // Reset state.
    do_reset();
    run_op("reset", '0, '0, 0);

    // Single request of three steps ends in S3.
    run_op("single", 4'b0001, pack_steps(3, 0, 0, 0), 0);

    // Wrap from S3 by five steps, then a zero-step operation.
    run_op("wrap", 4'b0100, pack_steps(0, 0, 5, 0), 0);
    run_op("zero", 4'b0010, pack_steps(0, 0, 0, 0), 0);
    run_op("gap", '0, '0, 0);

    // Round-robin with all requesters held high, one step each.
    do_reset();
    for (int i = 0; i < 5; i++)
      run_op($sformatf("rr%0d", i), 4'b1111, pack_steps(1, 1, 1, 1), 0);

    // Inputs changed mid-operation are ignored: six pulses still issued.
    run_op("midop", 4'b1000, pack_steps(0, 0, 0, 6), 1);

    // Move the pointer away from 0, then abort an operation with reset in its second STEP cycle.
    run_op("preabort", 4'b0010, pack_steps(0, 1, 0, 0), 0);
    req   = 4'b0100;
    steps = pack_steps(0, 0, 4, 0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check_outs("abort.s1", 4'b0100, 1'b1, 1'b0, m_cnt);
    @(posedge clock);
    #1;
    reset = 1'b1;
    req   = '0;
    @(negedge clock);
    check_outs("abort.s2", 4'b0100, 1'b1, 1'b0, m_cnt + 1);
    @(posedge clock);
    #1 reset = 1'b0;
    m_cnt = 0;
    m_ptr = 0;
    @(negedge clock);
    check_outs("abort.rst", '0, 1'b0, 1'b0, 0);
    @(posedge clock);
    #1;
    run_op("abort.nodone", '0, '0, 0);
    run_op("abort.ptr", 4'b1111, pack_steps(0, 0, 0, 0), 0);

    // Randomized operations, including idle cycles and post-grant input churn.
    for (int i = 0; i < 40; i++) begin
      r = N_REQ'($urandom_range(0, 15));
      s = SV_W'($urandom);
      run_op($sformatf("rnd%0d", i), r, s, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
